// File: rtl/tlul_a_arbiter_if.sv
// Bus bundle for the two-master TL-UL arbiter: packed upstream A/D channels
// plus the single downstream socket.
interface tlul_a_arbiter_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 1,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3
);
  // Upstream A channel, master i at slice i
  logic [1:0]                  m_a_valid;
  logic [1:0]                  m_a_ready;
  logic [2*OPCODE_WIDTH-1:0]   m_a_opcode;
  logic [2*PARAM_WIDTH-1:0]    m_a_param;
  logic [2*SIZE_WIDTH-1:0]     m_a_size;
  logic [2*SRC_WIDTH-1:0]      m_a_source;
  logic [2*ADDR_WIDTH-1:0]     m_a_address;
  logic [2*MASK_WIDTH-1:0]     m_a_mask;
  logic [2*DATA_WIDTH-1:0]     m_a_data;

  // Upstream D channel, fields broadcast to both masters
  logic [1:0]                  m_d_valid;
  logic [1:0]                  m_d_ready;
  logic [OPCODE_WIDTH-1:0]     m_d_opcode;
  logic [PARAM_WIDTH-1:0]      m_d_param;
  logic [SIZE_WIDTH-1:0]       m_d_size;
  logic [SRC_WIDTH-1:0]        m_d_source;
  logic [SINK_WIDTH-1:0]       m_d_sink;
  logic [DATA_WIDTH-1:0]       m_d_data;
  logic                        m_d_error;

  logic                        s_a_valid;
  logic                        s_a_ready;
  logic [OPCODE_WIDTH-1:0]     s_a_opcode;
  logic [PARAM_WIDTH-1:0]      s_a_param;
  logic [SIZE_WIDTH-1:0]       s_a_size;
  logic [SRC_WIDTH:0]          s_a_source;
  logic [ADDR_WIDTH-1:0]       s_a_address;
  logic [MASK_WIDTH-1:0]       s_a_mask;
  logic [DATA_WIDTH-1:0]       s_a_data;

  logic                        s_d_valid;
  logic                        s_d_ready;
  logic [OPCODE_WIDTH-1:0]     s_d_opcode;
  logic [PARAM_WIDTH-1:0]      s_d_param;
  logic [SIZE_WIDTH-1:0]       s_d_size;
  logic [SRC_WIDTH:0]          s_d_source;
  logic [SINK_WIDTH-1:0]       s_d_sink;
  logic [DATA_WIDTH-1:0]       s_d_data;
  logic                        s_d_error;

  modport slave (
    input  m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
           m_a_mask, m_a_data, m_d_ready,
           s_a_ready,
           s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_sink,
           s_d_data, s_d_error,
    output m_a_ready,
           m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_sink,
           m_d_data, m_d_error,
           s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address,
           s_a_mask, s_a_data,
           s_d_ready
  );

  modport master (
    output m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
           m_a_mask, m_a_data, m_d_ready,
           s_a_ready,
           s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_sink,
           s_d_data, s_d_error,
    input  m_a_ready,
           m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_sink,
           m_d_data, m_d_error,
           s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address,
           s_a_mask, s_a_data,
           s_d_ready
  );
endinterface

// File: rtl/tlul_a_arbiter.sv
// Two-master TL-UL arbiter: round-robin A channel with stall lock, D responses
// routed by source MSB, per-master outstanding throttling and error flag.
module tlul_a_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int SRC_WIDTH       = 1,
  parameter int SINK_WIDTH      = 1,
  parameter int OPCODE_WIDTH    = 3,
  parameter int PARAM_WIDTH     = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_100,
  input  logic                  reset_n,
  tlul_a_arbiter_if.slave       bus,
  output logic [7:0]            outstanding,
  output logic                  err_unexpected_d
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic {ARB, HOLD} state_e;

  state_e     state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       locked_idx_q, locked_idx_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic       err_q, err_d;

  logic [1:0] elig;
  logic       grant;
  logic       a_vld;
  logic       a_hs;
  logic [1:0] a_rdy;
  logic       d_idx;
  logic       d_hs;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = bus.m_a_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Once a request is presented and stalled, the lock keeps it on the socket
  // until accepted so the downstream sees stable valid/payload.
  always_comb begin
    state_d      = state_q;
    locked_idx_d = locked_idx_q;
    rr_ptr_d     = rr_ptr_q;
    grant        = rr_ptr_q;
    a_vld        = 1'b0;
    case (state_q)
      ARB: begin
        a_vld = reset_n && (|elig);
        if (!elig[rr_ptr_q] && elig[~rr_ptr_q]) grant = ~rr_ptr_q;
        if (a_vld && !bus.s_a_ready) begin
          state_d      = HOLD;
          locked_idx_d = grant;
        end
      end
      HOLD: begin
        grant = locked_idx_q;
        a_vld = reset_n && bus.m_a_valid[locked_idx_q];
        if (bus.s_a_ready) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (a_vld && bus.s_a_ready) rr_ptr_d = ~grant;
  end

  assign a_hs = a_vld && bus.s_a_ready;

  always_comb begin
    a_rdy        = 2'b00;
    a_rdy[grant] = a_vld && bus.s_a_ready;
  end

  assign bus.m_a_ready   = a_rdy;
  assign bus.s_a_valid   = a_vld;
  assign bus.s_a_opcode  = grant ? bus.m_a_opcode[OPCODE_WIDTH +: OPCODE_WIDTH]
                                 : bus.m_a_opcode[0 +: OPCODE_WIDTH];
  assign bus.s_a_param   = grant ? bus.m_a_param[PARAM_WIDTH +: PARAM_WIDTH]
                                 : bus.m_a_param[0 +: PARAM_WIDTH];
  assign bus.s_a_size    = grant ? bus.m_a_size[SIZE_WIDTH +: SIZE_WIDTH]
                                 : bus.m_a_size[0 +: SIZE_WIDTH];
  assign bus.s_a_address = grant ? bus.m_a_address[ADDR_WIDTH +: ADDR_WIDTH]
                                 : bus.m_a_address[0 +: ADDR_WIDTH];
  assign bus.s_a_mask    = grant ? bus.m_a_mask[MASK_WIDTH +: MASK_WIDTH]
                                 : bus.m_a_mask[0 +: MASK_WIDTH];
  assign bus.s_a_data    = grant ? bus.m_a_data[DATA_WIDTH +: DATA_WIDTH]
                                 : bus.m_a_data[0 +: DATA_WIDTH];
  assign bus.s_a_source  = {grant, grant ? bus.m_a_source[SRC_WIDTH +: SRC_WIDTH]
                                         : bus.m_a_source[0 +: SRC_WIDTH]};

  // The extra source MSB added on the A side names the owning master on D.
  assign d_idx             = bus.s_d_source[SRC_WIDTH];
  assign bus.m_d_valid     = (reset_n && bus.s_d_valid) ? (d_idx ? 2'b10 : 2'b01) : 2'b00;
  assign bus.s_d_ready     = reset_n && bus.m_d_ready[d_idx];
  assign d_hs              = bus.s_d_valid && bus.s_d_ready;
  assign bus.m_d_opcode    = bus.s_d_opcode;
  assign bus.m_d_param     = bus.s_d_param;
  assign bus.m_d_size      = bus.s_d_size;
  assign bus.m_d_source    = bus.s_d_source[SRC_WIDTH-1:0];
  assign bus.m_d_sink      = bus.s_d_sink;
  assign bus.m_d_data      = bus.s_d_data;
  assign bus.m_d_error     = bus.s_d_error;

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      logic inc, dec;
      inc      = a_hs && (grant == 1'(i));
      dec      = d_hs && (d_idx == 1'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec && !inc && (cnt_q[i] != 4'd0)) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
      // A response with nothing in flight is a protocol error; never underflow.
      if (dec && (cnt_q[i] == 4'd0)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= 1'b0;
      locked_idx_q <= 1'b0;
      cnt_q[0]     <= 4'd0;
      cnt_q[1]     <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      locked_idx_q <= locked_idx_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      err_q        <= err_d;
    end
  end

  assign outstanding      = {cnt_q[1], cnt_q[0]};
  assign err_unexpected_d = err_q;

endmodule
